alu_mul_sequencer: RTL and testbench
====================================

Name: alu_mul_sequencer

Overview:
Iterative shift-and-add multiplier controller that borrows the shared 32-bit EX-stage ALU (ADD op) to compute the low WIDTH bits of op_a*op_b.
Owns the ALU operand/opcode mux: when idle, the EX-stage ALUOP/BusA/BusB pass straight through; while multiplying, the sequencer drives the ALU and stalls the pipeline.
Sits beside the ALU in the EX stage, between ID/EX registers and the ALU inputs.

Parameters:
WIDTH, 32, datapath width; must match the ALU BusA/BusB/RES width.
CNT_W, 5, iteration counter width; equals clog2(WIDTH).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request a multiply; sampled only in IDLE
op_a  in  WIDTH  multiplicand, sampled with start
op_b  in  WIDTH  multiplier, sampled with start
ex_aluop  in  3  pipeline ALU opcode (pass-through when not RUN)
ex_busa  in  WIDTH  pipeline operand A (pass-through)
ex_busb  in  WIDTH  pipeline operand B (pass-through)
alu_res  in  WIDTH  combinational ALU RES fed back
alu_op  out  3  to ALU ALUOP
alu_a  out  WIDTH  to ALU BusA
alu_b  out  WIDTH  to ALU BusB
busy  out  1  high while in RUN
stall  out  1  pipeline stall = busy | (start & state==IDLE)
done  out  1  one-cycle pulse, product valid
product  out  WIDTH  registered low WIDTH bits of op_a*op_b; holds until next accepted start

Behaviour:
- States: IDLE, RUN, DONE. Encoding lives in the package.
- Reset: state=IDLE, acc=0, mcand=0, mplier=0, cnt=0, product=0, done=0, busy=0.
- Reset applies in any state, including mid-RUN. The operation is abandoned with no done pulse.
- IDLE with start=1 at edge t:
  - Load acc<=0, mcand<=op_a, mplier<=op_b, cnt<=0.
  - Next state is RUN if op_b!=0, else DONE with product<=0.
- start is ignored in RUN and DONE. No queuing.
- RUN, each cycle:
  - Drive alu_op=3'b000, alu_a=acc, alu_b=mcand.
  - At the edge: if mplier[0], acc<=alu_res (wraps mod 2^WIDTH).
  - mcand<=mcand<<1 (zero fill); mplier<=mplier>>1; cnt<=cnt+1.
- RUN exit when (mplier>>1)==0 or cnt==WIDTH-1:
  - next state DONE;
  - product<=final acc value, including this cycle's add if taken.
- Latency, start sampled at edge t, highest set bit of op_b at position k:
  - RUN occupies cycles t+1..t+k+1;
  - done=1 during cycle t+k+2;
  - op_b=0 gives done during t+1;
  - worst case (bit WIDTH-1 set) gives done during t+WIDTH+1.
- DONE: done=1 for exactly one cycle, busy=0, ALU is pass-through, then IDLE unconditionally.
- Pass-through (IDLE, DONE): alu_op=ex_aluop, alu_a=ex_busa, alu_b=ex_busb, combinational with no added latency.
- stall is combinational and may depend on start in the same cycle.
- No signedness: product is the low WIDTH bits regardless of the operands' sign interpretation.

Decomposition:
- Shared package alu_pkg:
  - ALU opcode constants: ALU_ADD=000, ALU_SUB=001, ALU_OR=010, ALU_NOR=011, ALU_AND=100.
  - Mul sequencer state enum: IDLE/RUN/DONE.
- One natural sub-module, alu_operand_mux: a 2-way mux selecting the sequencer or the pipeline drive of alu_op/alu_a/alu_b.
- The ALU itself is instantiated by the bench/top, not inside this block.

Test Plan:
- op_a=6, op_b=7, start at edge t:
  - RUN 3 cycles;
  - done pulse in cycle t+4 with product=42;
  - stall high in cycles t..t+3, low in cycle t+4.
- op_a=0x1234, op_b=0:
  - done in cycle t+1, product=0;
  - no RUN cycle, alu_op never forced to 000.
- op_a=0xFFFFFFFF, op_b=0xFFFFFFFF:
  - 32 RUN cycles; done in cycle t+33;
  - product=0x00000001 (wrap).
- op_a=0x80000000, op_b=2:
  - product=0x00000000; done in cycle t+3.
- Reset asserted mid-RUN (op_b=0xFF, 3 cycles after start):
  - next cycle state IDLE, busy=0, product=0;
  - no done pulse; a later start of 3*5 yields 15.
- Pass-through:
  - In IDLE, ex_aluop=001, ex_busa=10, ex_busb=3 gives alu_op=001, alu_a=10, alu_b=3 in the same cycle.
  - A second start pulsed during RUN is ignored; the product equals the first request.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU opcodes and multiply-sequencer state encoding for the EX stage.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_NOR = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/alu_operand_mux.sv
// Selects who drives the shared ALU: the multiply sequencer or the EX pipeline.
module alu_operand_mux #(
    parameter int WIDTH = 32
) (
    input  logic             sel,
    input  logic [2:0]       seq_op,
    input  logic [WIDTH-1:0] seq_a,
    input  logic [WIDTH-1:0] seq_b,
    input  logic [2:0]       pipe_op,
    input  logic [WIDTH-1:0] pipe_a,
    input  logic [WIDTH-1:0] pipe_b,
    output logic [2:0]       op,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b
);

    // Pure combinational steering; pipeline path has no added latency.
    always_comb begin
        op = sel ? seq_op : pipe_op;
        a  = sel ? seq_a  : pipe_a;
        b  = sel ? seq_b  : pipe_b;
    end

endmodule

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier that borrows the EX-stage ALU adder one bit per
// cycle, stalling the pipeline while it owns the ALU.
module alu_mul_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2:0]       ex_aluop,
    input  logic [WIDTH-1:0] ex_busa,
    input  logic [WIDTH-1:0] ex_busb,
    input  logic [WIDTH-1:0] alu_res,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    mul_state_e       state, state_next;
    logic [WIDTH-1:0] acc, acc_next;
    logic [WIDTH-1:0] mcand, mcand_next;
    logic [WIDTH-1:0] mplier, mplier_next;
    logic [WIDTH-1:0] prod_q, prod_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [WIDTH-1:0] acc_step;

    // State and datapath registers; reset abandons any multiply in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            prod_q <= '0;
        end else begin
            state  <= state_next;
            acc    <= acc_next;
            mcand  <= mcand_next;
            mplier <= mplier_next;
            cnt    <= cnt_next;
            prod_q <= prod_next;
        end
    end

    // Next-state and datapath update; the ALU sum (acc + mcand) is only
    // kept when the current multiplier LSB is set.
    always_comb begin
        state_next  = state;
        acc_next    = acc;
        mcand_next  = mcand;
        mplier_next = mplier;
        cnt_next    = cnt;
        prod_next   = prod_q;
        acc_step    = mplier[0] ? alu_res : acc;
        case (state)
            IDLE: begin
                if (start) begin
                    acc_next    = '0;
                    mcand_next  = op_a;
                    mplier_next = op_b;
                    cnt_next    = '0;
                    if (op_b == '0) begin
                        state_next = DONE;
                        prod_next  = '0;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                acc_next    = acc_step;
                mcand_next  = mcand << 1;
                mplier_next = mplier >> 1;
                cnt_next    = cnt + 1'b1;
                // Stop early once no multiplier bits remain above this one.
                if ((mplier >> 1) == '0 || cnt == CNT_W'(WIDTH - 1)) begin
                    state_next = DONE;
                    prod_next  = acc_step;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded straight from state; stall also covers the
    // request cycle so the pipeline freezes before the ALU is taken.
    always_comb begin
        busy    = (state == RUN);
        done    = (state == DONE);
        stall   = busy | (start & (state == IDLE));
        product = prod_q;
    end

    alu_operand_mux #(.WIDTH(WIDTH)) u_mux (
        .sel     (busy),
        .seq_op  (ALU_ADD),
        .seq_a   (acc),
        .seq_b   (mcand),
        .pipe_op (ex_aluop),
        .pipe_a  (ex_busa),
        .pipe_b  (ex_busb),
        .op      (alu_op),
        .a       (alu_a),
        .b       (alu_b)
    );

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed plus randomized bench for alu_mul_sequencer with a stand-in ALU.
module tb_alu_mul_sequencer;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [W-1:0] op_a, op_b, ex_busa, ex_busb, alu_res, alu_a, alu_b, product;
    logic [2:0]   ex_aluop, alu_op;
    logic         busy, stall, done;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    alu_mul_sequencer #(.WIDTH(W), .CNT_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .ex_aluop (ex_aluop),
        .ex_busa  (ex_busa),
        .ex_busb  (ex_busb),
        .alu_res  (alu_res),
        .alu_op   (alu_op),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .busy     (busy),
        .stall    (stall),
        .done     (done),
        .product  (product)
    );

    // Stand-in EX-stage ALU fed from the sequencer's operand mux.
    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD: alu_res = alu_a + alu_b;
            ALU_SUB: alu_res = alu_a - alu_b;
            ALU_OR:  alu_res = alu_a | alu_b;
            ALU_NOR: alu_res = ~(alu_a | alu_b);
            ALU_AND: alu_res = alu_a & alu_b;
            default: alu_res = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edges after the sampling edge until done shows: highest set bit k
    // gives k+1 RUN cycles, then done; a zero multiplier goes straight to done.
    function automatic int ref_edges(input logic [W-1:0] b);
        int k = -1;
        for (int i = 0; i < W; i++) if (b[i]) k = i;
        return (k < 0) ? 0 : k + 1;
    endfunction

    // Issue one multiply from IDLE and check timing, product and pass-through.
    task automatic run_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] exp_p;
        int exp_n, n, runs, stalls, bad_op;
        bit seen;
        exp_p = a * b;
        exp_n = ref_edges(b);
        op_a = a; op_b = b; start = 1'b1;
        #1;
        chk({tag, " stall_req"}, {31'd0, stall}, 32'd1);
        tick();
        start = 1'b0;
        n = 0; runs = 0; stalls = 0; bad_op = 0; seen = 1'b0;
        while (n <= W + 4 && !seen) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) runs++;
                if (stall) stalls++;
                if (busy && alu_op !== ALU_ADD) bad_op++;
                tick();
                n++;
            end
        end
        chk({tag, " latency"}, seen ? 32'(n) : 32'hFFFF_FFFF, 32'(exp_n));
        chk({tag, " run_cycles"}, 32'(runs), 32'(exp_n));
        chk({tag, " stall_cycles"}, 32'(stalls), 32'(exp_n));
        chk({tag, " run_aluop"}, 32'(bad_op), 32'd0);
        chk({tag, " product"}, product, exp_p);
        chk({tag, " stall_done"}, {31'd0, stall}, 32'd0);
        chk({tag, " passthru_done"}, alu_a, ex_busa);
        tick();
        chk({tag, " done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, " product_hold"}, product, exp_p);
    endtask

    initial begin
        int seen_done;
        logic [W-1:0] ra, rb;

        reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
        ex_aluop = ALU_SUB; ex_busa = 32'd10; ex_busb = 32'd3;
        tick(); tick();
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset product", product, 32'd0);
        chk("reset stall", {31'd0, stall}, 32'd0);
        reset = 1'b0;
        tick();

        // Pass-through in IDLE, same cycle.
        chk("pt aluop", {29'd0, alu_op}, 32'd1);
        chk("pt busa", alu_a, 32'd10);
        chk("pt busb", alu_b, 32'd3);
        ex_aluop = ALU_NOR; ex_busa = $urandom; ex_busb = $urandom;
        #1;
        chk("pt aluop2", {29'd0, alu_op}, {29'd0, ALU_NOR});
        chk("pt busa2", alu_a, ex_busa);
        chk("pt busb2", alu_b, ex_busb);
        chk("pt res", alu_res, ~(ex_busa | ex_busb));
        tick();

        run_mul("6x7", 32'd6, 32'd7);
        ex_aluop = ALU_OR;
        run_mul("zero_b", 32'h1234, 32'd0);
        run_mul("all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_mul("msb_x2", 32'h8000_0000, 32'd2);

        // Reset three cycles into a long multiply.
        op_a = 32'd9; op_b = 32'hFF; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("midrun busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst product", product, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst stall", {31'd0, stall}, 32'd0);
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) seen_done++;
            tick();
        end
        chk("rst no_done", 32'(seen_done), 32'd0);
        run_mul("3x5", 32'd3, 32'd5);

        // A second start during RUN is dropped; old product holds meanwhile.
        op_a = 32'd11; op_b = 32'h1F; start = 1'b1;
        tick();
        op_a = 32'd99; op_b = 32'd99;
        chk("hold during run", product, 32'd15);
        tick(); tick();
        start = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 20 && seen_done == 0; i++) begin
            if (done) seen_done = 1; else tick();
        end
        chk("restart seen_done", 32'(seen_done), 32'd1);
        chk("restart product", product, 32'd341);
        tick(); tick();
        chk("restart idle", {31'd0, busy}, 32'd0);

        // Randomized operands against the arithmetic reference.
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) rb = '0;
            ex_busa = $urandom; ex_busb = $urandom;
            ex_aluop = 3'($urandom_range(0, 4));
            run_mul($sformatf("rand%0d", i), ra, rb);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
